// File: rtl/swap_pair_collector.sv
// Downstream checker for the two-bit swap stage: verifies the a/b swap invariant,
// deserialises both lanes LSB-first into words and tracks errors and lock.
module swap_pair_collector #(
    parameter int WORD_W = 8,
    parameter int ERR_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              a_i,
    input  logic              b_i,
    output logic [WORD_W-1:0] word_a_o,
    output logic [WORD_W-1:0] word_b_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    output logic              err_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic              locked_o
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [3:0] LOCK_TGT = 4'(LOCK_N);

    // The transient acquisition step is folded into the IDLE->RUN transition.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              prev_a;
    logic              prev_b;
    logic [WORD_W-2:0] part_a;
    logic [WORD_W-2:0] part_b;
    logic [3:0]        good_cnt;

    logic check;
    logic mismatch;
    logic good;
    logic word_done;
    logic load;
    logic transfer;

    always_comb begin
        check     = en_i && (state == ST_RUN);
        mismatch  = check && ((a_i != prev_b) || (b_i != prev_a));
        good      = check && !mismatch;
        word_done = en_i && (bit_cnt == LAST_BIT);
        transfer  = valid_o && ready_i;
        load      = word_done && (!valid_o || ready_i);
    end

    // Sequencing and bit packing; the final bit of a word goes straight to the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            prev_a  <= 1'b0;
            prev_b  <= 1'b0;
            part_a  <= '0;
            part_b  <= '0;
        end else if (!en_i) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
        end else begin
            state  <= ST_RUN;
            prev_a <= a_i;
            prev_b <= b_i;
            if (word_done) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt         <= bit_cnt + 1'b1;
                part_a[bit_cnt] <= a_i;
                part_b[bit_cnt] <= b_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_a_o  <= '0;
            word_b_o  <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (load) begin
                word_a_o <= {a_i, part_a};
                word_b_o <= {b_i, part_b};
                valid_o  <= 1'b1;
            end else if (transfer) begin
                valid_o <= 1'b0;
            end
            if (word_done && !load) begin
                overrun_o <= 1'b1;
            end
        end
    end

    // Error pulse, saturating error count and lock tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
            good_cnt  <= '0;
            locked_o  <= 1'b0;
        end else begin
            err_o <= mismatch;
            if (mismatch && (err_cnt_o != {ERR_W{1'b1}})) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
            if (!en_i || mismatch) begin
                good_cnt <= '0;
                locked_o <= 1'b0;
            end else if (good && (good_cnt != LOCK_TGT)) begin
                good_cnt <= good_cnt + 4'd1;
                locked_o <= ((good_cnt + 4'd1) == LOCK_TGT);
            end
        end
    end

endmodule

// File: tb/tb_swap_pair_collector.sv
// Scoreboard bench for swap_pair_collector: directed scenarios plus random traffic
// against a queue-based behavioural model.
module tb_swap_pair_collector;

    localparam int WORD_W = 8;
    localparam int ERR_W  = 8;
    localparam int LOCK_N = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i;
    logic              a_i;
    logic              b_i;
    logic              ready_i;
    logic [WORD_W-1:0] word_a_o;
    logic [WORD_W-1:0] word_b_o;
    logic              valid_o;
    logic              overrun_o;
    logic              err_o;
    logic [ERR_W-1:0]  err_cnt_o;
    logic              locked_o;

    swap_pair_collector #(.WORD_W(WORD_W), .ERR_W(ERR_W), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .a_i(a_i), .b_i(b_i),
        .word_a_o(word_a_o), .word_b_o(word_b_o), .valid_o(valid_o), .ready_i(ready_i),
        .overrun_o(overrun_o), .err_o(err_o), .err_cnt_o(err_cnt_o), .locked_o(locked_o)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [2*WORD_W-1:0] sb_q[$];

    // Reference model: what the outputs should be after the coming edge.
    logic        m_running;
    logic        m_prev_a, m_prev_b;
    logic        bits_a[$];
    logic        bits_b[$];
    int          m_good;
    logic        m_locked;
    logic        m_err;
    int          m_err_cnt;
    logic        m_valid;
    logic        m_overrun;
    logic [WORD_W-1:0] m_word_a, m_word_b;

    logic gen_a, gen_b;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_running = 1'b0; m_prev_a = 1'b0; m_prev_b = 1'b0;
        bits_a.delete(); bits_b.delete();
        m_good = 0; m_locked = 1'b0; m_err = 1'b0; m_err_cnt = 0;
        m_valid = 1'b0; m_overrun = 1'b0; m_word_a = '0; m_word_b = '0;
        sb_q.delete();
    endtask

    task automatic modelStep(input logic r, input logic e, input logic a, input logic b, input logic rdy);
        logic transfer;
        logic loaded;
        logic [WORD_W-1:0] wa, wb;
        if (r) begin
            modelReset();
            return;
        end
        transfer = m_valid && rdy;
        loaded = 1'b0;
        m_err = 1'b0;
        if (e) begin
            if (m_running) begin
                if (a != m_prev_b || b != m_prev_a) begin
                    m_err = 1'b1;
                    m_err_cnt = (m_err_cnt < ERR_MAX) ? m_err_cnt + 1 : ERR_MAX;
                    m_good = 0;
                    m_locked = 1'b0;
                end else begin
                    m_good = (m_good < LOCK_N) ? m_good + 1 : LOCK_N;
                    m_locked = (m_good == LOCK_N);
                end
            end
            m_running = 1'b1;
            m_prev_a = a;
            m_prev_b = b;
            bits_a.push_back(a);
            bits_b.push_back(b);
            if (bits_a.size() == WORD_W) begin
                wa = '0; wb = '0;
                for (int k = 0; k < WORD_W; k++) begin
                    wa[k] = bits_a[k];
                    wb[k] = bits_b[k];
                end
                if (!m_valid || transfer) begin
                    loaded = 1'b1;
                    m_word_a = wa;
                    m_word_b = wb;
                    sb_q.push_back({wa, wb});
                end else begin
                    m_overrun = 1'b1;
                end
                bits_a.delete();
                bits_b.delete();
            end
        end else begin
            m_running = 1'b0;
            bits_a.delete();
            bits_b.delete();
            m_good = 0;
            m_locked = 1'b0;
        end
        if (loaded) m_valid = 1'b1;
        else if (transfer) m_valid = 1'b0;
    endtask

    task automatic checkOutput();
        checkVal("valid_o", 32'(valid_o), 32'(m_valid));
        checkVal("err_o", 32'(err_o), 32'(m_err));
        checkVal("err_cnt_o", 32'(err_cnt_o), 32'(m_err_cnt));
        checkVal("locked_o", 32'(locked_o), 32'(m_locked));
        checkVal("overrun_o", 32'(overrun_o), 32'(m_overrun));
        checkVal("word_a_o", 32'(word_a_o), 32'(m_word_a));
        checkVal("word_b_o", 32'(word_b_o), 32'(m_word_b));
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic a, input logic b, input logic rdy);
        @(negedge clk);
        rst = r; en_i = e; a_i = a; b_i = b; ready_i = rdy;
        modelStep(r, e, a, b, rdy);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // One sample of a correct swap stream, optionally with b inverted.
    task automatic streamStep(input logic e, input logic rdy, input logic flip_b);
        logic b;
        b = flip_b ? ~gen_b : gen_b;
        applyStimulus(1'b0, e, gen_a, b, rdy);
        if (e) begin
            gen_a = ~gen_a;
            gen_b = ~gen_b;
        end
    endtask

    // Monitor: compares the presented pair with the scoreboard, pops on each transfer.
    always @(negedge clk) begin
        #1;
        if (rst === 1'b0 && valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkVal("sb_unexpected_valid", 32'(valid_o), 32'(0));
            end else begin
                checkVal("sb_pair", 32'({word_a_o, word_b_o}), 32'(sb_q[0]));
                if (ready_i === 1'b1) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; en_i = 1'b0; a_i = 1'b0; b_i = 1'b0; ready_i = 1'b0;
        modelReset();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkVal("reset_valid", 32'(valid_o), 32'(0));

        gen_a = 1'b1; gen_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            streamStep(1'b1, 1'b1, 1'b0);
            if (i == 4) checkVal("s1_locked_5th", 32'(locked_o), 32'(1));
        end
        checkVal("s1_word_a", 32'(word_a_o), 32'h55);
        checkVal("s1_word_b", 32'(word_b_o), 32'hAA);
        repeat (12) streamStep(1'b1, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        gen_a = 1'b1; gen_b = 1'b0;
        for (int i = 0; i < 20; i++) streamStep(1'b1, 1'b1, i == 3);
        checkVal("err_cnt_after_inject", 32'(err_cnt_o != 0), 32'(1));

        repeat (20) streamStep(1'b1, 1'b0, 1'b0);
        checkVal("overrun_sticky", 32'(overrun_o), 32'(1));
        repeat (16) streamStep(1'b1, 1'b1, 1'b0);

        repeat (24) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkVal("const0_locked", 32'(locked_o), 32'(1));

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        gen_a = 1'b1; gen_b = 1'b0;
        repeat (5) streamStep(1'b1, 1'b1, 1'b0);
        repeat (2) streamStep(1'b0, 1'b1, 1'b0);
        checkVal("en_drop_unlocked", 32'(locked_o), 32'(0));
        repeat (16) streamStep(1'b1, 1'b1, 1'b0);

        repeat (12) streamStep(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("rst_valid", 32'(valid_o), 32'(0));
        checkVal("rst_overrun", 32'(overrun_o), 32'(0));
        checkVal("rst_word_a", 32'(word_a_o), 32'(0));
        gen_a = 1'b1; gen_b = 1'b0;
        repeat (8) streamStep(1'b1, 1'b1, 1'b0);
        checkVal("post_rst_word_a", 32'(word_a_o), 32'h55);
        checkVal("post_rst_word_b", 32'(word_b_o), 32'hAA);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499) == 0) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                streamStep($urandom_range(15) != 0, $urandom_range(3) != 0,
                           $urandom_range(19) == 0);
            end
        end

        repeat (300) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkVal("err_cnt_saturated", 32'(err_cnt_o), 32'(ERR_MAX));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
